uart_tx: RTL
============

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, meaning the number of payload bits per frame.
REQ-002 The module SHALL have parameter PARITY_EN, default 1, meaning 1 = a parity bit is sent after the data, 0 = no parity bit.
REQ-003 The module SHALL have parameter PARITY_ODD, default 0, meaning 0 = even parity, 1 = odd parity.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all logic is sensitive to its rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The module SHALL have port tx_data, input, DATA_WIDTH bits: the payload.
REQ-007 The module SHALL have port tx_valid, input, 1 bit: the payload is offered.
REQ-008 The module SHALL have port tx_ready, output, 1 bit: the block can accept a payload.
REQ-009 The module SHALL have port next_bit, input, 1 bit: bit-period-elapsed level from the bit timer.
REQ-010 The module SHALL have port reset_timer, output, 1 bit: holds or restarts the bit timer while high.
REQ-011 The module SHALL have port tx, output, 1 bit: the serial line, idle high.
REQ-012 The module SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-013 The module SHALL have port tx_done, output, 1 bit: a one-cycle pulse at the end of the stop bit.

Function
REQ-014 The FSM states SHALL be IDLE, START, DATA, PARITY and STOP; all outputs SHALL be registered.
REQ-015 tx_ready SHALL be 1 only in IDLE; accept = tx_valid && tx_ready.
REQ-016 On accept at cycle N, the block SHALL:
- latch tx_data;
- compute parity = XOR(tx_data) ^ PARITY_ODD;
- enter START;
- drive tx=0, busy=1 and reset_timer=0 from cycle N+1.
REQ-017 tick SHALL be next_bit && !reset_timer; next_bit SHALL be ignored while reset_timer=1 or in IDLE.
REQ-018 On tick, the FSM SHALL advance one state or bit and drive reset_timer=1 for exactly one cycle, then 0 again.
REQ-019 Transitions SHALL be:
- START -> DATA with idx=0;
- DATA idx<DATA_WIDTH-1 -> DATA with idx+1;
- DATA idx=DATA_WIDTH-1 -> PARITY if PARITY_EN, else -> STOP;
- PARITY -> STOP;
- STOP -> IDLE.
REQ-020 tx SHALL be:
- 0 in START;
- data[idx] in DATA, LSB first;
- the parity bit in PARITY;
- 1 in STOP and IDLE.
REQ-021 tx SHALL change only on the cycle after a tick, never mid-bit.
REQ-022 The bit index SHALL be $clog2(DATA_WIDTH) bits wide, SHALL be cleared on entry to DATA, and SHALL NOT wrap within a frame.
REQ-023 On STOP tick:
- tx_done=1 for one cycle;
- busy=0 and tx_ready=1 on the next cycle;
- reset_timer=1 and held in IDLE.
REQ-024 tx_valid while busy SHALL be ignored; tx_data changes after accept SHALL NOT affect the frame in flight.
REQ-025 Back-to-back frames SHALL have a minimum gap of one IDLE cycle (tx=1) between a stop-bit tick and the next accept.
REQ-026 A tick and tx_valid in the same cycle SHALL be resolved by the state alone; no frame is accepted outside IDLE.

Reset
REQ-027 While reset=1, asynchronously, outputs SHALL be:
- state=IDLE, idx=0;
- tx=1, tx_ready=1, busy=0, tx_done=0;
- reset_timer=1.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately; tx returns to 1 with no partial stop bit and no tx_done.
REQ-029 After reset deasserts, the first accept SHALL be possible on the first rising clk edge.

Verification
REQ-030 PARITY_EN=1, PARITY_ODD=0, tx_data=0xA5, timer model with a 16-cycle period -> tx per 16-cycle bit: 0,1,0,1,0,0,1,0,1,0,1; one tx_done pulse; 176 cycles from accept to tx_ready.
REQ-031 PARITY_EN=0, tx_data=0x00 -> 10 bits 0,0,0,0,0,0,0,0,0,1; no parity bit.
REQ-032 PARITY_ODD=1, tx_data=0x01 -> parity bit = 0; tx_data=0x00 -> parity bit = 1.
REQ-033 tx_valid held high with a new tx_data (0x3C) during a frame of 0xC3 -> the line carries 0xC3 unchanged; 0x3C is accepted only after tx_ready, one IDLE cycle later.
REQ-034 reset pulsed during DATA bit 4 -> tx=1, reset_timer=1, busy=0 the same cycle; no tx_done; a subsequent frame of 0x55 is correct.
REQ-035 next_bit forced high while reset_timer=1 or in IDLE -> no state change, tx stays constant.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH payload bits LSB first, optional parity, stop bit.
// Bit timing comes from an external timer via next_bit/reset_timer.
module uart_tx #(
   parameter int DATA_WIDTH = 8,
   parameter bit PARITY_EN  = 1'b1,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   input  logic                  next_bit,
   output logic                  reset_timer,
   output logic                  tx,
   output logic                  busy,
   output logic                  tx_done
);

   localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] data_q;
   logic [IDX_W-1:0]      idx;
   logic [IDX_W-1:0]      idx_nxt;
   logic                  parity_bit;
   logic                  tick;

   // A timer that is still being restarted cannot signal an elapsed period.
   assign tick    = next_bit && !reset_timer;
   assign idx_nxt = idx + 1'b1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         idx         <= '0;
         data_q      <= '0;
         parity_bit  <= 1'b0;
         tx          <= 1'b1;
         tx_ready    <= 1'b1;
         busy        <= 1'b0;
         tx_done     <= 1'b0;
         reset_timer <= 1'b1;
      end else begin
         tx_done <= 1'b0;
         // One restart cycle after every tick; IDLE keeps the timer held.
         if (state != IDLE) reset_timer <= tick;
         case (state)
            IDLE: begin
               if (tx_valid && tx_ready) begin
                  data_q      <= tx_data;
                  parity_bit  <= ^tx_data ^ PARITY_ODD;
                  state       <= START;
                  tx          <= 1'b0;
                  busy        <= 1'b1;
                  tx_ready    <= 1'b0;
                  reset_timer <= 1'b0;
               end
            end
            START: begin
               if (tick) begin
                  state <= DATA;
                  idx   <= '0;
                  tx    <= data_q[0];
               end
            end
            DATA: begin
               if (tick) begin
                  if (idx == LAST_IDX) begin
                     if (PARITY_EN) begin
                        state <= PARITY;
                        tx    <= parity_bit;
                     end else begin
                        state <= STOP;
                        tx    <= 1'b1;
                     end
                  end else begin
                     idx <= idx_nxt;
                     tx  <= data_q[idx_nxt];
                  end
               end
            end
            PARITY: begin
               if (tick) begin
                  state <= STOP;
                  tx    <= 1'b1;
               end
            end
            STOP: begin
               if (tick) begin
                  state    <= IDLE;
                  busy     <= 1'b0;
                  tx_ready <= 1'b1;
                  tx_done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
